// File: rtl/scnn_ip_slice_streamer.sv
// rtl/scnn_ip_slice_streamer.sv - captures one compressed activation frame and streams its non-zeros slice by slice
//
// Purpose: holds a four-slice compressed frame (values, zero-run indices, per-slice
// counts) and emits PARAM_F non-zeros per beat, each tagged with its absolute dense
// coordinate rebuilt from the zero runs. Empty slices cost one silent cycle each.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_valid / load_ready    frame capture handshake (ready only in IDLE)
//   comp_arr, comp_ind         per-slice non-zero values and preceding zero-run lengths
//   inputs_per_slice           per-slice non-zero count (clamped to slice length)
//   out_valid / out_ready      output beat handshake
//   out_data, out_coord        per-lane value and dense position (0 in idle lanes)
//   out_lane_valid             per-lane valid, packed from lane 0
//   out_slice                  slice index of the current beat
//   out_slice_last             last beat of the current slice
//   out_frame_last             last beat of the frame
//   busy                       streaming in progress
module scnn_ip_slice_streamer #(
    parameter int PARAM_ISIZE = 64,
    parameter int PARAM_F     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [3:0][PARAM_ISIZE/4-1:0][15:0]  comp_arr,
    input  logic [3:0][PARAM_ISIZE/4-1:0][7:0]   comp_ind,
    input  logic [3:0][7:0]                      inputs_per_slice,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PARAM_F-1:0][15:0]             out_data,
    output logic [PARAM_F-1:0][7:0]              out_coord,
    output logic [PARAM_F-1:0]                   out_lane_valid,
    output logic [1:0]                           out_slice,
    output logic                                 out_slice_last,
    output logic                                 out_frame_last,
    output logic                                 busy
);

    localparam int         SLICE   = PARAM_ISIZE / 4;
    localparam int         SW      = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam logic [7:0] SLICE_W = 8'(SLICE);
    localparam logic [8:0] F_W     = 9'(PARAM_F);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t                             state_q, state_d;
    logic [3:0][SLICE-1:0][15:0]        arr_q, arr_d;
    logic [3:0][SLICE-1:0][7:0]         ind_q, ind_d;
    logic [3:0][7:0]                    cnt_q, cnt_d;
    logic [1:0]                         s_q, s_d;
    logic [7:0]                         k_q, k_d;
    logic [7:0]                         next_pos_q, next_pos_d;

    logic [3:0][7:0]                    cnt_clamped;
    logic [7:0]                         cur_cnt;
    logic                               stream_c;
    logic                               slice_last_c;
    logic                               higher_empty;
    logic [7:0]                         acc;
    logic [7:0]                         idx;
    logic [7:0]                         last_coord;
    logic                               advance;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_clamped[i] = (inputs_per_slice[i] > SLICE_W) ? SLICE_W : inputs_per_slice[i];
        end
    end

    // Output datapath: lane coordinates are a running prefix sum of the zero runs
    // starting from next_pos, plus one position per non-zero already placed.
    always_comb begin
        cur_cnt        = cnt_q[s_q];
        stream_c       = (state_q == ST_STREAM) && (cur_cnt != 8'd0);
        slice_last_c   = ({1'b0, k_q} + F_W) >= {1'b0, cur_cnt};
        higher_empty   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i > int'(s_q)) && (cnt_q[i] != 8'd0)) begin
                higher_empty = 1'b0;
            end
        end
        acc            = next_pos_q;
        idx            = '0;
        last_coord     = next_pos_q;
        out_data       = '0;
        out_coord      = '0;
        out_lane_valid = '0;
        for (int j = 0; j < PARAM_F; j++) begin
            idx = k_q + 8'(j);
            if (stream_c && (idx < cur_cnt)) begin
                acc               = acc + ind_q[s_q][idx[SW-1:0]];
                out_coord[j]      = acc + 8'(j);
                out_data[j]       = arr_q[s_q][idx[SW-1:0]];
                out_lane_valid[j] = 1'b1;
                last_coord        = acc + 8'(j);
            end
        end
        out_valid      = stream_c;
        out_slice      = s_q;
        out_slice_last = stream_c && slice_last_c;
        out_frame_last = stream_c && slice_last_c && higher_empty;
        busy           = (state_q == ST_STREAM);
        load_ready     = (state_q == ST_IDLE);
    end

    always_comb begin
        state_d    = state_q;
        arr_d      = arr_q;
        ind_d      = ind_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        k_d        = k_q;
        next_pos_d = next_pos_q;
        advance    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    arr_d      = comp_arr;
                    ind_d      = comp_ind;
                    cnt_d      = cnt_clamped;
                    s_d        = 2'd0;
                    k_d        = 8'd0;
                    next_pos_d = 8'd0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (cur_cnt == 8'd0) begin
                    // Empty slice: one silent cycle, then move on.
                    advance = 1'b1;
                end else if (out_ready) begin
                    next_pos_d = last_coord + 8'd1;
                    if (slice_last_c) begin
                        k_d     = 8'd0;
                        advance = 1'b1;
                    end else begin
                        k_d = k_q + 8'(PARAM_F);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (s_q == 2'd3) begin
                state_d = ST_IDLE;
                s_d     = 2'd0;
            end else begin
                s_d = s_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arr_q      <= '0;
            ind_q      <= '0;
            cnt_q      <= '0;
            s_q        <= '0;
            k_q        <= '0;
            next_pos_q <= '0;
        end else begin
            state_q    <= state_d;
            arr_q      <= arr_d;
            ind_q      <= ind_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            k_q        <= k_d;
            next_pos_q <= next_pos_d;
        end
    end

endmodule

// File: tb/tb_scnn_ip_slice_streamer.sv
// tb/tb_scnn_ip_slice_streamer.sv - scoreboard bench for scnn_ip_slice_streamer
module tb_scnn_ip_slice_streamer;

    localparam int ISIZE = 64;
    localparam int F     = 4;
    localparam int SLICE = ISIZE / 4;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          load_valid = 1'b0;
    logic                          load_ready;
    logic [3:0][SLICE-1:0][15:0]   comp_arr = '0;
    logic [3:0][SLICE-1:0][7:0]    comp_ind = '0;
    logic [3:0][7:0]               inputs_per_slice = '0;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic [F-1:0][15:0]            out_data;
    logic [F-1:0][7:0]             out_coord;
    logic [F-1:0]                  out_lane_valid;
    logic [1:0]                    out_slice;
    logic                          out_slice_last;
    logic                          out_frame_last;
    logic                          busy;

    scnn_ip_slice_streamer #(.PARAM_ISIZE(ISIZE), .PARAM_F(F)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .comp_arr         (comp_arr),
        .comp_ind         (comp_ind),
        .inputs_per_slice (inputs_per_slice),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_coord        (out_coord),
        .out_lane_valid   (out_lane_valid),
        .out_slice        (out_slice),
        .out_slice_last   (out_slice_last),
        .out_frame_last   (out_frame_last),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [F-1:0][15:0] data;
        logic [F-1:0][7:0]  coord;
        logic [F-1:0]       lv;
        logic [1:0]         slice;
        logic               sl;
        logic               fl;
    } beat_t;

    beat_t exp_q[$];

    logic [3:0][SLICE-1:0][15:0] f_arr;
    logic [3:0][SLICE-1:0][7:0]  f_ind;
    logic [3:0][7:0]             f_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frame();
        f_arr = '0;
        f_ind = '0;
        f_cnt = '0;
    endtask

    // Reference: walk the dense vector; each non-zero sits ind+1 past the previous one.
    task automatic push_model();
        int    prev;
        int    pos;
        int    c[4];
        beat_t e;
        prev = -1;
        for (int s = 0; s < 4; s++) c[s] = (int'(f_cnt[s]) > SLICE) ? SLICE : int'(f_cnt[s]);
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < c[s]; b += F) begin
                e.data  = '0;
                e.coord = '0;
                e.lv    = '0;
                for (int j = 0; j < F; j++) begin
                    if (b + j < c[s]) begin
                        pos        = (prev + int'(f_ind[s][b+j]) + 1) % 256;
                        prev       = pos;
                        e.data[j]  = f_arr[s][b+j];
                        e.coord[j] = 8'(pos);
                        e.lv[j]    = 1'b1;
                    end
                end
                e.slice = 2'(s);
                e.sl    = (b + F >= c[s]);
                e.fl    = e.sl;
                for (int t = s + 1; t < 4; t++) if (c[t] != 0) e.fl = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cmp_beat(input bit pop);
        beat_t e;
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_coord", 64'(out_coord), 64'(e.coord));
            chk("out_lane_valid", 64'(out_lane_valid), 64'(e.lv));
            chk("out_slice", 64'(out_slice), 64'(e.slice));
            chk("out_slice_last", 64'(out_slice_last), 64'(e.sl));
            chk("out_frame_last", 64'(out_frame_last), 64'(e.fl));
            if (pop) void'(exp_q.pop_front());
        end
    endtask

    task automatic load_frame();
        @(negedge clk);
        chk("load_ready_at_load", 64'(load_ready), 64'd1);
        comp_arr         = f_arr;
        comp_ind         = f_ind;
        inputs_per_slice = f_cnt;
        load_valid       = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Consumes beats until the scoreboard is empty and the DUT is back in IDLE.
    task automatic drain(input int budget, input int stall_at, input int stall_len, output int cycles);
        int beats;
        int stall_left;
        bit stalled;
        beats      = 0;
        stall_left = 0;
        stalled    = 1'b0;
        cycles     = 0;
        while (cycles < budget) begin
            if (out_valid) begin
                if (beats == stall_at && !stalled) begin
                    stalled    = 1'b1;
                    stall_left = stall_len;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    cmp_beat(1'b0);
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    cmp_beat(1'b1);
                    beats++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (exp_q.size() == 0 && load_ready) break;
            @(negedge clk);
            cycles++;
        end
        chk("drain_within_budget", 64'(cycles < budget), 64'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        int    cyc;
        beat_t e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_coord", 64'(out_coord), 64'd0);
        chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        chk("rst_out_slice", 64'(out_slice), 64'd0);
        chk("rst_flags", 64'({out_slice_last, out_frame_last}), 64'd0);
        rst_n = 1'b1;

        // All-zero frame: four silent skip cycles
        clear_frame();
        load_frame();
        for (int i = 0; i < 4; i++) begin
            chk("zero_busy", 64'(busy), 64'd1);
            chk("zero_no_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        chk("zero_load_ready_back", 64'(load_ready), 64'd1);
        chk("zero_busy_low", 64'(busy), 64'd0);

        // Slice 0 full with values 1..16, zero indices: 4 beats then 3 skips
        clear_frame();
        f_cnt[0] = 8'd16;
        for (int i = 0; i < 16; i++) f_arr[0][i] = 16'(i + 1);
        push_model();
        load_frame();
        chk("first_beat_latency", 64'(out_valid), 64'd1);
        drain(50, -1, 0, cyc);
        chk("dense_slice_cycles", 64'(cyc), 64'd7);

        // Sparse frame across slices 0 and 1, expectations written out by hand
        clear_frame();
        f_cnt[0]    = 8'd1;
        f_arr[0][0] = 16'h00AA;
        f_ind[0][0] = 8'd15;
        f_cnt[1]    = 8'd2;
        f_arr[1][0] = 16'h0001;
        f_arr[1][1] = 16'h0002;
        f_ind[1][0] = 8'd3;
        f_ind[1][1] = 8'd0;
        e.data = '0; e.coord = '0;
        e.data[0] = 16'h00AA; e.coord[0] = 8'd15; e.lv = 4'b0001;
        e.slice = 2'd0; e.sl = 1'b1; e.fl = 1'b0;
        exp_q.push_back(e);
        e.data = '0; e.coord = '0;
        e.data[0] = 16'h0001; e.data[1] = 16'h0002;
        e.coord[0] = 8'd19; e.coord[1] = 8'd20; e.lv = 4'b0011;
        e.slice = 2'd1; e.sl = 1'b1; e.fl = 1'b1;
        exp_q.push_back(e);
        load_frame();
        drain(50, -1, 0, cyc);

        // Dense frame, beat 2 stalled for 3 cycles
        clear_frame();
        for (int s = 0; s < 4; s++) begin
            f_cnt[s] = 8'd16;
            for (int i = 0; i < 16; i++) f_arr[s][i] = 16'($urandom_range(1, 16'hFFFF));
        end
        push_model();
        load_frame();
        drain(100, 1, 3, cyc);
        chk("stall_cycles", 64'(cyc), 64'd19);

        // Reset during beat 2, then a fresh frame
        push_model();
        load_frame();
        out_ready = 1'b1;
        cmp_beat(1'b1);
        @(negedge clk);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_load_ready", 64'(load_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_lane_valid", 64'(out_lane_valid), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_frame();
        f_cnt[0] = 8'd16;
        for (int i = 0; i < 16; i++) f_arr[0][i] = 16'(16'h0100 + i);
        push_model();
        load_frame();
        drain(50, -1, 0, cyc);

        // load_valid held high across a whole frame; second frame differs
        clear_frame();
        f_cnt[1]    = 8'd3;
        f_arr[1][0] = 16'h0011; f_ind[1][0] = 8'd2;
        f_arr[1][1] = 16'h0022; f_ind[1][1] = 8'd0;
        f_arr[1][2] = 16'h0033; f_ind[1][2] = 8'd5;
        push_model();
        @(negedge clk);
        comp_arr         = f_arr;
        comp_ind         = f_ind;
        inputs_per_slice = f_cnt;
        load_valid       = 1'b1;
        @(negedge clk);
        clear_frame();
        f_cnt[0] = 8'd5;
        for (int i = 0; i < 5; i++) begin
            f_arr[0][i] = 16'(16'h0100 + i);
            f_ind[0][i] = 8'(i % 3);
        end
        f_cnt[2] = 8'd200;
        for (int i = 0; i < 16; i++) f_arr[2][i] = 16'(16'h0200 + i);
        f_cnt[3]    = 8'd2;
        f_arr[3][0] = 16'h0301; f_ind[3][0] = 8'd1;
        f_arr[3][1] = 16'h0302; f_ind[3][1] = 8'd1;
        comp_arr         = f_arr;
        comp_ind         = f_ind;
        inputs_per_slice = f_cnt;
        drain(50, -1, 0, cyc);
        chk("held_idle_cycle", 64'(cyc), 64'd4);
        chk("held_load_ready", 64'(load_ready), 64'd1);
        push_model();
        @(negedge clk);
        load_valid = 1'b0;
        chk("held_second_first_beat", 64'(out_valid), 64'd1);
        drain(50, -1, 0, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scnn_ip_slice_streamer.md
# scnn_ip_slice_streamer

Sequential stage directly downstream of the input compression block. It captures one compressed activation frame and streams the non-zero values slice by slice. Each frame is four slices of PARAM_ISIZE/4 entries, carrying values, zero-run indices and per-slice counts. Output beats carry PARAM_F values per cycle, each with its absolute coordinate rebuilt from the zero-run indices, ready for the multiplier array.

## Interface
- PARAM_ISIZE, 64: dense input vector length; multiple of 4, at most 256.
- PARAM_F, 4: values per output beat; power of 2, at most PARAM_ISIZE/4.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load_valid  in  1  a compressed frame is presented.
- load_ready  out  1  high only in IDLE; a load is accepted on a cycle with load_valid && load_ready.
- comp_arr  in  [3:0][PARAM_ISIZE/4-1:0][15:0]  non-zero values, packed from entry 0 of each slice.
- comp_ind  in  [3:0][PARAM_ISIZE/4-1:0][7:0]  zeros between the previous non-zero in the whole vector and this one. The count is not reset at slice boundaries.
- inputs_per_slice  in  [3:0][7:0]  non-zero count per slice; values above PARAM_ISIZE/4 are clamped to PARAM_ISIZE/4 at capture.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  [PARAM_F-1:0][15:0]  values; 0 in invalid lanes.
- out_coord  out  [PARAM_F-1:0][7:0]  absolute dense position, 0..PARAM_ISIZE-1; 0 in invalid lanes.
- out_lane_valid  out  [PARAM_F-1:0]  per-lane valid, filled from lane 0 upward.
- out_slice  out  2  slice index of the current beat.
- out_slice_last  out  1  last beat of the current slice.
- out_frame_last  out  1  last beat of the frame.
- busy  out  1  high in STREAM.

## Operation
- States: IDLE and STREAM.
- Registered state: captured frame, slice pointer s, in-slice pointer k, and next_pos (8 bit). next_pos is the dense position just after the last emitted non-zero.
- IDLE, on an accepted load:
  - capture all inputs;
  - set s=0, k=0, next_pos=0;
  - go to STREAM.
- STREAM, slice with clamped count cnt[s]==0:
  - out_valid stays 0;
  - spend one cycle skipping the slice;
  - then s+1, or go to IDLE if s==3.
- STREAM, cnt[s]>0:
  - lane j is valid iff k+j < cnt[s];
  - coord_j = next_pos + (comp_ind[s][k] + ... + comp_ind[s][k+j]) + j, computed mod 256.
- On handshake (out_valid && out_ready):
  - next_pos = coord of the last valid lane + 1;
  - k += PARAM_F;
  - if k+PARAM_F >= cnt[s], then k=0 and s+1 (or go to IDLE if s==3).
- Flags:
  - out_slice_last = (k+PARAM_F >= cnt[s]);
  - out_frame_last = out_slice_last && cnt of every slice above s is 0.
- An all-zero frame emits no beats.
- load_valid is ignored while busy.
- Malformed input (coordinates past PARAM_ISIZE-1) wraps mod 256 without any error indication.

## Timing
- Reset (asynchronous, applied any time including mid-frame):
  - state IDLE, load_ready=1;
  - out_valid=0, busy=0;
  - all data, coord, lane_valid, slice and flag outputs 0;
  - the in-flight frame is discarded.
- The load is accepted at edge N. The first beat is valid in the cycle after edge N if slice 0 is non-empty.
- Outputs are combinational from registered state. They hold stable while out_valid && !out_ready.
- out_valid never drops without a handshake, except on reset.
- With out_ready held high, one beat per cycle. A slice takes ceil(cnt/PARAM_F) cycles, or 1 cycle if empty.
- load_ready rises in the cycle after the final beat's handshake, or after the final skip cycle.
- Back-to-back frames therefore have one IDLE cycle between them.

## Test plan
- All slices cnt=0, load at edge N:
  - no out_valid;
  - busy high for 4 cycles;
  - load_ready high again in the cycle after edge N+4.
- Slice 0 cnt=16 with values 1..16, all indices 0, other slices empty, out_ready=1:
  - 4 beats with coords 0..15 and lane_valid 1111;
  - beat 4 has out_slice_last=1 and out_frame_last=1;
  - then a skip of slices 1..3.
- Slice 0 cnt=1, value 0x00AA, ind 15; slice 1 cnt=2, values 0x0001 and 0x0002, inds 3 and 0:
  - beat 1: coord 15, lane_valid 0001, out_slice=0, out_frame_last=0;
  - beat 2: coords 19 and 20, lane_valid 0011, out_slice=1, out_frame_last=1.
- Dense frame with out_ready low for 3 cycles on beat 2:
  - all outputs held bit-identical;
  - no pointer advance;
  - resumes with beat 2 coords 4..7.
- rst_n pulsed low during beat 2:
  - out_valid=0 and load_ready=1 immediately;
  - a fresh load after release streams from coord 0 correctly.
- load_valid held high for the whole frame:
  - the second frame is captured only in the single IDLE cycle;
  - its first beat follows one cycle later.
